// File: rtl/ibex_cap_pkg.sv
// Shared types for the capability-aware instruction fetch path:
// outstanding-request entries, fetch FSM states and next-word arithmetic.
package ibex_cap_pkg;

    localparam int unsigned CAP_W    = 93;
    localparam int unsigned ADDR_MSB = 31;

    typedef struct packed {
        logic [CAP_W-1:0] cap;
        logic             discard;
    } outst_entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } fetch_state_e;

    // Next word address: drop the halfword offset, step one word, wrap at 2^32.
    function automatic logic [ADDR_MSB:0] next_word_addr(input logic [ADDR_MSB:0] addr);
        return {addr[ADDR_MSB:2], 2'b00} + 32'd4;
    endfunction

endpackage

// File: rtl/ibex_fetch_outst_queue.sv
// In-order queue of granted-but-unanswered fetch requests. Each entry keeps
// the full capability PC and a discard flag that branch flushes can set.
module ibex_fetch_outst_queue
    import ibex_cap_pkg::*;
#(
    parameter  int unsigned MAX_OUTST = 2,
    localparam int unsigned CNT_W     = $clog2(MAX_OUTST + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  outst_entry_t     push_entry_i,
    input  logic             pop_i,
    input  logic             discard_all_i,
    output logic [CNT_W-1:0] count_o,
    output outst_entry_t     head_o
);

    outst_entry_t [MAX_OUTST-1:0] entries_q, entries_d;
    logic         [CNT_W-1:0]     count_q, count_d;
    logic                         pop_en;

    assign pop_en = pop_i && (count_q != '0);

    // Pop shifts toward the head before the push lands, so a simultaneous
    // pop and push writes the new entry into the slot just vacated.
    always_comb begin
        entries_d = entries_q;
        count_d   = count_q;
        if (pop_en) begin
            for (int i = 0; i < int'(MAX_OUTST) - 1; i++) begin
                entries_d[i] = entries_q[i+1];
            end
            entries_d[MAX_OUTST-1] = '0;
            count_d = count_d - CNT_W'(1);
        end
        if (push_i) begin
            for (int i = 0; i < int'(MAX_OUTST); i++) begin
                if (CNT_W'(i) == count_d) begin
                    entries_d[i] = push_entry_i;
                end
            end
            count_d = count_d + CNT_W'(1);
        end
        if (discard_all_i) begin
            for (int i = 0; i < int'(MAX_OUTST); i++) begin
                entries_d[i].discard = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            entries_q <= '0;
            count_q   <= '0;
        end else begin
            entries_q <= entries_d;
            count_q   <= count_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = entries_q[0];

endmodule

// File: rtl/ibex_fetch_req_ctrl.sv
// Instruction-side request controller: issues word-aligned fetches, tracks
// in-flight capability PCs and pushes returned words into the fetch FIFO.
module ibex_fetch_req_ctrl
    import ibex_cap_pkg::*;
#(
    parameter int unsigned MAX_OUTST = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_i,
    input  logic             branch_i,
    input  logic [CAP_W-1:0] branch_cap_i,
    output logic             busy_o,
    output logic             instr_req_o,
    input  logic             instr_gnt_i,
    output logic [31:0]      instr_addr_o,
    input  logic             instr_rvalid_i,
    input  logic [31:0]      instr_rdata_i,
    output logic             fifo_clear_o,
    output logic             fifo_valid_o,
    input  logic             fifo_ready_i,
    output logic [CAP_W-1:0] fifo_addr_o,
    output logic [31:0]      fifo_rdata_o
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);

    // Handshakes: instr_req_o is held with a stable address until instr_gnt_i;
    // responses return in grant order, one per instr_rvalid_i. The FIFO push
    // (fifo_valid_o) is not back-pressured: fifo_ready_i only gates new
    // requests, so every in-flight word already has a slot reserved.

    fetch_state_e     state_q, state_d;
    logic [CAP_W-1:0] fetch_cap_q, fetch_cap_d;
    logic [CAP_W-1:0] req_cap_q, req_cap_d;
    logic             stale_q, stale_d;
    logic             booted_q;

    logic [CNT_W-1:0] count_q, cnt_after;
    outst_entry_t     head, push_entry;
    logic             gnt_fire, rsp_pop, issue_ok, load_req;

    assign gnt_fire = (state_q == REQ) && instr_gnt_i;
    assign rsp_pop  = instr_rvalid_i && (count_q != '0);

    // Occupancy after this cycle's grant and response, so a back-to-back
    // request never pushes the queue past MAX_OUTST.
    assign cnt_after = count_q + CNT_W'(gnt_fire) - CNT_W'(rsp_pop);
    assign issue_ok  = booted_q && req_i && !branch_i && fifo_ready_i
                       && (cnt_after < CNT_W'(MAX_OUTST));
    assign load_req  = issue_ok && ((state_q == IDLE) || gnt_fire);

    assign push_entry = '{cap: req_cap_q, discard: stale_q | branch_i};

    ibex_fetch_outst_queue #(
        .MAX_OUTST (MAX_OUTST)
    ) u_outst_queue (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .push_i        (gnt_fire),
        .push_entry_i  (push_entry),
        .pop_i         (rsp_pop),
        .discard_all_i (branch_i),
        .count_o       (count_q),
        .head_o        (head)
    );

    // A stale grant must not advance the PC: fetch_cap_q already holds the target.
    always_comb begin
        fetch_cap_d = fetch_cap_q;
        if (branch_i) begin
            fetch_cap_d = branch_cap_i;
        end else if (gnt_fire && !stale_q) begin
            fetch_cap_d = {fetch_cap_q[CAP_W-1:ADDR_MSB+1],
                           next_word_addr(fetch_cap_q[ADDR_MSB:0])};
        end
    end

    always_comb begin
        state_d   = state_q;
        req_cap_d = req_cap_q;
        stale_d   = stale_q;
        case (state_q)
            IDLE: if (load_req) state_d = REQ;
            REQ:  if (gnt_fire) state_d = load_req ? REQ : IDLE;
            default: state_d = IDLE;
        endcase
        if (load_req) begin
            req_cap_d = fetch_cap_d;
        end
        if (gnt_fire) begin
            stale_d = 1'b0;
        end else if (branch_i && (state_q == REQ)) begin
            stale_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            fetch_cap_q <= '0;
            req_cap_q   <= '0;
            stale_q     <= 1'b0;
            booted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_cap_q <= fetch_cap_d;
            req_cap_q   <= req_cap_d;
            stale_q     <= stale_d;
            booted_q    <= booted_q | branch_i;
        end
    end

    assign instr_req_o  = (state_q == REQ);
    assign instr_addr_o = {req_cap_q[ADDR_MSB:2], 2'b00};
    assign busy_o       = (state_q == REQ) || (count_q != '0);

    assign fifo_clear_o = branch_i;
    assign fifo_valid_o = rsp_pop && !head.discard && !branch_i;
    assign fifo_addr_o  = head.cap;
    assign fifo_rdata_o = instr_rdata_i;

    a_rvalid_needs_outstanding: assert property (
        @(posedge clk_i) disable iff (!rst_ni) instr_rvalid_i |-> (count_q != '0)
    );

endmodule
